// File: rtl/usb_frame_loader_pkg.sv
// Shared types and constants for the USB frame loader: FSM state encoding,
// error codes reported on err_code, and the default frame start byte.
package usb_frame_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN_H   = 3'd2,
        S_LEN_L   = 3'd3,
        S_PAYLOAD = 3'd4,
        S_CSUM    = 3'd5,
        S_DONE    = 3'd6,
        S_ERR     = 3'd7
    } state_e;

    localparam logic [1:0] ERR_CSUM     = 2'd0;
    localparam logic [1:0] ERR_LEN      = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERFLOW = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/usb_frame_loader_skid_fifo.sv
// Two-entry byte FIFO absorbing the read that usb_input may still complete
// after hold rises. Pushes while full are ignored; the caller flags overflow.
module usb_skid_fifo (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] data_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push_s;
    logic       do_pop_s;

    assign full_o    = (count_q == 2'd2);
    assign empty_o   = (count_q == 2'd0);
    assign do_push_s = push_i & ~full_o;
    assign do_pop_s  = pop_i & ~empty_o;
    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and occupancy; push and pop may coincide
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            mem_q[0] <= 8'h00;
            mem_q[1] <= 8'h00;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/usb_frame_loader.sv
// Parses SYNC/CMD/LEN/payload/CSUM frames from the usb_input byte stream,
// writes payload bytes through a ready/valid port and reports done/error.
module usb_frame_loader
    import usb_frame_loader_pkg::*;
#(
    parameter int         ADDR_W  = 16,
    parameter int         MAX_LEN = 1024,
    parameter logic [7:0] SYNC    = SYNC_DEFAULT,
    parameter int         TIMEOUT = 2_700_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              hold,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              frame_done,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic [7:0]        frame_cmd,
    output logic [15:0]       frame_len
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [15:0]       len_q, len_d;
    logic [7:0]        csum_q, csum_d;
    logic [15:0]       idx_q, idx_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        frame_cmd_q, frame_cmd_d;
    logic [15:0]       frame_len_q, frame_len_d;
    logic [1:0]        err_code_q, err_code_d;

    logic [7:0]  head_s;
    logic [1:0]  fifo_count_s;
    logic        fifo_full_s;
    logic        fifo_empty_s;
    logic        pop_s;
    logic        push_s;
    logic        overflow_s;
    logic        accept_s;
    logic        in_frame_s;
    logic        tmo_hit_s;
    logic [15:0] len_full_s;

    assign push_s     = byte_valid & ~fifo_full_s;
    assign overflow_s = byte_valid & fifo_full_s;
    assign accept_s   = wr_en_q & wr_ready;
    assign in_frame_s = (state_q == S_CMD) | (state_q == S_LEN_H) | (state_q == S_LEN_L)
                      | (state_q == S_PAYLOAD) | (state_q == S_CSUM);
    assign tmo_hit_s  = (cnt_q == TW'(TIMEOUT)) & fifo_empty_s;
    assign len_full_s = {len_q[15:8], head_s};

    usb_skid_fifo u_skid (
        .clock_i (clock),
        .reset_i (reset),
        .push_i  (push_s),
        .data_i  (byte_in),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .count_o (fifo_count_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Frame parser: next state, datapath updates and skid pop request
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        len_d       = len_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        wr_en_d     = wr_en_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_cmd_d = frame_cmd_q;
        frame_len_d = frame_len_q;
        err_code_d  = err_code_q;
        pop_s       = 1'b0;
        if (overflow_s) begin
            state_d    = S_ERR;
            err_code_d = ERR_OVERFLOW;
            wr_en_d    = 1'b0;
        end else if (in_frame_s && tmo_hit_s && !wr_en_q) begin
            state_d    = S_ERR;
            err_code_d = ERR_TIMEOUT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pop_s = ~fifo_empty_s;
                    if (!fifo_empty_s && head_s == SYNC) begin
                        state_d = S_CMD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CMD: begin
                    pop_s = ~fifo_empty_s;
                    if (!fifo_empty_s) begin
                        cmd_d   = head_s;
                        csum_d  = head_s;
                        state_d = S_LEN_H;
                    end else begin
                        state_d = S_CMD;
                    end
                end
                S_LEN_H: begin
                    pop_s = ~fifo_empty_s;
                    if (!fifo_empty_s) begin
                        len_d[15:8] = head_s;
                        csum_d      = csum_step(csum_q, head_s);
                        state_d     = S_LEN_L;
                    end else begin
                        state_d = S_LEN_H;
                    end
                end
                S_LEN_L: begin
                    pop_s = ~fifo_empty_s;
                    if (!fifo_empty_s) begin
                        len_d  = len_full_s;
                        csum_d = csum_step(csum_q, head_s);
                        idx_d  = 16'd0;
                        if (len_full_s > 16'(MAX_LEN)) begin
                            state_d    = S_ERR;
                            err_code_d = ERR_LEN;
                        end else if (len_full_s == 16'd0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_PAYLOAD;
                        end
                    end else begin
                        state_d = S_LEN_L;
                    end
                end
                S_PAYLOAD: begin
                    // A new byte is fetched only once the previous write has been taken
                    if (wr_en_q) begin
                        if (wr_ready) begin
                            wr_en_d = 1'b0;
                            csum_d  = csum_step(csum_q, wr_data_q);
                            idx_d   = idx_q + 16'd1;
                            if (idx_q == len_q - 16'd1) begin
                                state_d = S_CSUM;
                            end else begin
                                state_d = S_PAYLOAD;
                            end
                        end else begin
                            state_d = S_PAYLOAD;
                        end
                    end else if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ADDR_W'(idx_q);
                        wr_data_d = head_s;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
                S_CSUM: begin
                    pop_s = ~fifo_empty_s;
                    if (!fifo_empty_s && head_s == csum_q) begin
                        state_d     = S_DONE;
                        frame_cmd_d = cmd_q;
                        frame_len_d = len_q;
                    end else if (!fifo_empty_s) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_CSUM;
                    end else begin
                        state_d = S_CSUM;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                S_ERR:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Inter-byte idle counter; a stalled write is not idleness
    always_comb begin
        cnt_d = cnt_q;
        if (!in_frame_s || pop_s || accept_s) begin
            cnt_d = '0;
        end else if (wr_en_q && !wr_ready) begin
            cnt_d = cnt_q;
        end else if (cnt_q != TW'(TIMEOUT)) begin
            cnt_d = cnt_q + TW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cmd_q       <= 8'h00;
            len_q       <= 16'h0000;
            csum_q      <= 8'h00;
            idx_q       <= 16'h0000;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
            frame_cmd_q <= 8'h00;
            frame_len_q <= 16'h0000;
            err_code_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_cmd_q <= frame_cmd_d;
            frame_len_q <= frame_len_d;
            err_code_q  <= err_code_d;
        end
    end

    assign hold       = reset | (fifo_count_s != 2'd0)
                      | ((state_q == S_PAYLOAD) & wr_en_q & ~wr_ready);
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = (state_q == S_DONE);
    assign frame_err  = (state_q == S_ERR);
    assign err_code   = err_code_q;
    assign frame_cmd  = frame_cmd_q;
    assign frame_len  = frame_len_q;

endmodule

// File: tb/tb_usb_frame_loader.sv
// Randomised bench for usb_frame_loader: a hold-respecting byte source, a
// frame-rule reference model and a write/pulse scoreboard.
module tb_usb_frame_loader;

    localparam int TMO = 300;
    typedef logic [7:0] bq_t[$];

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  byte_in = 8'h00;
    logic        byte_valid = 1'b0;
    logic        wr_ready = 1'b0;
    logic        hold, wr_en, frame_done, frame_err;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  err_code;
    logic [7:0]  frame_cmd;
    logic [15:0] frame_len;

    int tests_run = 0;
    int tests_failed = 0;

    bq_t         src_q;
    logic [23:0] wr_log[$];
    int          done_cnt = 0;
    int          err_cnt = 0;
    logic [7:0]  last_cmd = 8'h00;
    logic [15:0] last_len = 16'h0000;
    logic [1:0]  last_code = 2'd0;
    int          ready_mode = 0;
    int          stall_left = 0;
    bit          stall_arm = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [7:0]  prev_data = 8'h00;

    usb_frame_loader #(.TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .hold(hold), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .frame_done(frame_done), .frame_err(frame_err),
        .err_code(err_code), .frame_cmd(frame_cmd), .frame_len(frame_len)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/pulse monitor, sampled on the falling edge
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !frame_err) begin
                check_eq("wr_en_held", 32'(wr_en), 32'd1);
                check_eq("wr_addr_held", 32'(wr_addr), 32'(prev_addr));
                check_eq("wr_data_held", 32'(wr_data), 32'(prev_data));
            end
            if (wr_en && !wr_ready) check_eq("hold_on_stall", 32'(hold), 32'd1);
            if (wr_en && wr_ready) wr_log.push_back({wr_addr, wr_data});
            if (frame_done) begin
                done_cnt++;
                last_cmd = frame_cmd;
                last_len = frame_len;
            end
            if (frame_err) begin
                err_cnt++;
                last_code = err_code;
            end
            prev_stall = wr_en & ~wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
        if (stall_arm && wr_en) begin
            stall_left = 50;
            stall_arm  = 1'b0;
        end
        if (stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
        end else begin
            case (ready_mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = 1'b0;
            endcase
        end
        #1;
        if (!hold && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
            byte_in    = src_q.pop_front();
            byte_valid = 1'b1;
        end else begin
            byte_valid = 1'b0;
        end
    endtask

    // Reference: find SYNC, then apply the frame rules to the bytes that follow
    task automatic model(input bq_t b, output int kind, output int code, output int cmd,
                         output int len, output bq_t pay);
        int i = 0;
        logic [7:0] cs;
        kind = 0; code = 0; cmd = 0; len = 0; pay = {};
        while (i < b.size() && b[i] != 8'hA5) i++;
        i++;
        cmd = int'(b[i]);
        len = int'({b[i+1], b[i+2]});
        if (len > 1024) begin
            kind = 2; code = 1;
            return;
        end
        cs = b[i] ^ b[i+1] ^ b[i+2];
        for (int k = 0; k < len; k++) begin
            pay.push_back(b[i+3+k]);
            cs = cs ^ b[i+3+k];
        end
        if (b[i+3+len] == cs) kind = 1;
        else begin kind = 2; code = 0; end
    endtask

    task automatic build(input logic [7:0] cmd, input int len, input bit bad, input int junk,
                         output bq_t b);
        logic [15:0] l;
        logic [7:0]  cs, d;
        l = 16'(len);
        b = {};
        for (int j = 0; j < junk; j++) begin
            d = 8'($urandom_range(0, 255));
            b.push_back(d == 8'hA5 ? 8'h00 : d);
        end
        b.push_back(8'hA5); b.push_back(cmd); b.push_back(l[15:8]); b.push_back(l[7:0]);
        cs = cmd ^ l[15:8] ^ l[7:0];
        if (len <= 1024) begin
            for (int k = 0; k < len; k++) begin
                d = 8'($urandom_range(0, 255));
                b.push_back(d);
                cs = cs ^ d;
            end
            b.push_back(bad ? (cs ^ 8'h01) : cs);
        end
    endtask

    task automatic wait_event(input int base, input int limit);
        for (int c = 0; c < limit && (done_cnt + err_cnt) == base; c++) tick();
        check_eq("event_seen", 32'(done_cnt + err_cnt - base), 32'd1);
        for (int c = 0; c < 12; c++) tick();
    endtask

    task automatic compare(input string tag, input int kind, input int code, input int cmd,
                           input int len, input bq_t pay, input int d0, input int e0, input int w0);
        int n;
        check_eq({tag, "_done"}, 32'(done_cnt - d0), (kind == 1) ? 32'd1 : 32'd0);
        check_eq({tag, "_err"}, 32'(err_cnt - e0), (kind == 2) ? 32'd1 : 32'd0);
        if (kind == 1) begin
            check_eq({tag, "_cmd"}, 32'(last_cmd), 32'(cmd));
            check_eq({tag, "_len"}, 32'(last_len), 32'(len));
        end else begin
            check_eq({tag, "_code"}, 32'(last_code), 32'(code));
        end
        n = wr_log.size() - w0;
        check_eq({tag, "_nwr"}, 32'(n), 32'(pay.size()));
        if (n > pay.size()) n = pay.size();
        for (int k = 0; k < n; k++)
            check_eq({tag, "_wr"}, 32'(wr_log[w0+k]), {8'h00, 16'(k), pay[k]});
    endtask

    task automatic do_frame(input string tag, input bq_t b, input int mode, input bit stall);
        int kind, code, cmd, len, d0, e0, w0;
        bq_t pay;
        model(b, kind, code, cmd, len, pay);
        d0 = done_cnt; e0 = err_cnt; w0 = wr_log.size();
        ready_mode = mode;
        stall_arm  = stall;
        foreach (b[k]) src_q.push_back(b[k]);
        wait_event(d0 + e0, 20000);
        compare(tag, kind, code, cmd, len, pay, d0, e0, w0);
    endtask

    initial begin
        bq_t b, pay;
        int d0, e0, w0, lim;
        logic [7:0] cs;

        repeat (3) @(posedge clock);
        #1;
        check_eq("rst_hold", 32'(hold), 32'd1);
        check_eq("rst_outs", 32'({wr_en, frame_done, frame_err, err_code}), 32'd0);
        check_eq("rst_frame", 32'({frame_cmd, frame_len}), 32'd0);
        check_eq("rst_wr", 32'({wr_addr, wr_data}), 32'd0);
        reset = 1'b0;

        cs = 8'h01 ^ 8'h00 ^ 8'h03 ^ 8'h10 ^ 8'h20 ^ 8'h30;
        b = {8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, cs};
        do_frame("good3", b, 0, 1'b0);
        b[7] = cs ^ 8'h10;
        do_frame("badcsum", b, 0, 1'b0);
        b = {8'hA5, 8'h02, 8'h04, 8'h01};
        do_frame("len1025", b, 0, 1'b0);
        build(8'h33, 6, 1'b0, 0, b);
        do_frame("stall", b, 0, 1'b1);
        build(8'h44, 0, 1'b0, 1, b);
        do_frame("len0", b, 0, 1'b0);
        build(8'h55, 1024, 1'b0, 0, b);
        do_frame("len1024", b, 0, 1'b0);

        // Timeout mid-payload, then a clean frame
        d0 = done_cnt; e0 = err_cnt; w0 = wr_log.size();
        ready_mode = 0;
        src_q = {8'hA5, 8'h01, 8'h00, 8'h03, 8'h10};
        wait_event(d0 + e0, TMO + 200);
        pay = {8'h10};
        compare("timeout", 2, 2, 0, 0, pay, d0, e0, w0);
        b = {8'hA5, 8'h01, 8'h00, 8'h03, 8'h10, 8'h20, 8'h30, cs};
        do_frame("after_tmo", b, 1, 1'b0);

        // Overflow: consumer stalled on a pending write, three blind pushes
        d0 = done_cnt; e0 = err_cnt; w0 = wr_log.size();
        ready_mode = 2;
        src_q = {8'hA5, 8'h07, 8'h00, 8'h05, 8'h11};
        lim = 0;
        while (!wr_en && lim < 100) begin tick(); lim++; end
        check_eq("ovf_pending", 32'(wr_en), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #2;
            byte_in = 8'h22 + 8'(k);
            byte_valid = 1'b1;
        end
        @(posedge clock); #2;
        byte_valid = 1'b0;
        ready_mode = 0;
        wait_event(d0 + e0, 100);
        pay = {};
        compare("overflow", 2, 3, 0, 0, pay, d0, e0, w0);

        // Reset in the middle of a payload
        ready_mode = 2;
        src_q = {8'hA5, 8'h05, 8'h00, 8'h04, 8'h44, 8'h55};
        lim = 0;
        while (!wr_en && lim < 100) begin tick(); lim++; end
        @(posedge clock); #1;
        reset = 1'b1;
        src_q.delete();
        byte_valid = 1'b0;
        #2;
        check_eq("mid_rst_hold", 32'(hold), 32'd1);
        check_eq("mid_rst_outs", 32'({wr_en, frame_done, frame_err, err_code}), 32'd0);
        check_eq("mid_rst_frame", 32'({frame_cmd, frame_len}), 32'd0);
        repeat (3) tick();
        reset = 1'b0;
        d0 = done_cnt; e0 = err_cnt; w0 = wr_log.size();
        ready_mode = 0;
        repeat (30) tick();
        check_eq("post_rst_quiet", 32'(done_cnt + err_cnt - d0 - e0), 32'd0);
        check_eq("post_rst_nowr", 32'(wr_log.size() - w0), 32'd0);

        for (int t = 0; t < 16; t++) begin
            int len;
            len = ($urandom_range(0, 9) == 0) ? 1025 + int'($urandom_range(0, 100))
                                              : int'($urandom_range(0, 24));
            build(8'($urandom_range(0, 255)), len, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 2)), b);
            do_frame("rand", b, 1, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
